// File: rtl/sram_arb.sv
// sram_arb: two-client round-robin arbiter and sequencer for a single-port
// synchronous SRAM. Requests are issued to the SRAM from registers; read data
// comes back to the issuing client three edges after acceptance.
module sram_arb #(
  parameter  int DEPTH   = 16,
  parameter  int WIDTH   = 8,
  localparam int DEPTH_B = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rstn,
  // client 0
  input  logic               req0_valid,
  input  logic               req0_we,
  input  logic [DEPTH_B-1:0] req0_ad,
  input  logic [WIDTH-1:0]   req0_wd,
  output logic               req0_ready,
  output logic               rsp0_valid,
  output logic [WIDTH-1:0]   rsp0_rd,
  // client 1
  input  logic               req1_valid,
  input  logic               req1_we,
  input  logic [DEPTH_B-1:0] req1_ad,
  input  logic [WIDTH-1:0]   req1_wd,
  output logic               req1_ready,
  output logic               rsp1_valid,
  output logic [WIDTH-1:0]   rsp1_rd,
  // SRAM port
  output logic               cs,
  output logic               we,
  output logic [DEPTH_B-1:0] ad,
  output logic [WIDTH-1:0]   wd,
  input  logic [WIDTH-1:0]   rd
);

  // Round-robin history: the client granted at the most recent acceptance.
  logic               r_last;

  // Stage 1: issue register driving the SRAM pins directly.
  logic               r_cs;
  logic               r_we;
  logic [DEPTH_B-1:0] r_ad;
  logic [WIDTH-1:0]   r_wd;
  logic               r_id;

  // Stage 2: return register, marks that rd carries read data this cycle.
  logic               r_pend;
  logic               r_pid;

  // Response registers.
  logic               r_rsp0_valid;
  logic               r_rsp1_valid;
  logic [WIDTH-1:0]   r_rsp0_rd;
  logic [WIDTH-1:0]   r_rsp1_rd;

  logic               w_grant0;
  logic               w_grant1;
  logic               w_accept;
  logic               w_sel_we;
  logic [DEPTH_B-1:0] w_sel_ad;
  logic [WIDTH-1:0]   w_sel_wd;

  // Grant from the valids and the history bit only; nothing granted in reset.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (rstn) begin
      if (req0_valid && req1_valid) begin
        w_grant0 = r_last;
        w_grant1 = ~r_last;
      end else begin
        w_grant0 = req0_valid;
        w_grant1 = req1_valid;
      end
    end
  end

  assign w_accept = w_grant0 | w_grant1;

  // Select the granted client's request fields for the issue register.
  always_comb begin
    if (w_grant1) begin
      w_sel_we = req1_we;
      w_sel_ad = req1_ad;
      w_sel_wd = req1_wd;
    end else begin
      w_sel_we = req0_we;
      w_sel_ad = req0_ad;
      w_sel_wd = req0_wd;
    end
  end

  // Remember which client won the last acceptance; reset favours client 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= w_grant1;
    end
  end

  // Issue stage: launch the accepted request, otherwise idle with ad/wd held.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cs <= 1'b0;
      r_we <= 1'b0;
      r_ad <= '0;
      r_wd <= '0;
      r_id <= 1'b0;
    end else if (w_accept) begin
      r_cs <= 1'b1;
      r_we <= w_sel_we;
      r_ad <= w_sel_ad;
      r_wd <= w_sel_wd;
      r_id <= w_grant1;
    end else begin
      r_cs <= 1'b0;
      r_we <= 1'b0;
    end
  end

  // Return stage: follow a read one cycle behind its SRAM access.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend <= 1'b0;
      r_pid  <= 1'b0;
    end else begin
      r_pend <= r_cs & ~r_we;
      r_pid  <= r_id;
    end
  end

  // Capture read data for the owning client and pulse its valid once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_rd    <= '0;
      r_rsp1_rd    <= '0;
    end else begin
      r_rsp0_valid <= r_pend & ~r_pid;
      r_rsp1_valid <= r_pend & r_pid;
      if (r_pend && !r_pid) begin
        r_rsp0_rd <= rd;
      end
      if (r_pend && r_pid) begin
        r_rsp1_rd <= rd;
      end
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp0_rd    = r_rsp0_rd;
  assign rsp1_rd    = r_rsp1_rd;
  assign cs         = r_cs;
  assign we         = r_we;
  assign ad         = r_ad;
  assign wd         = r_wd;

endmodule

// File: tb/tb_sram_arb.sv
// tb_sram_arb: directed stimulus for sram_arb with a behavioural SRAM, a
// reference memory, and a per-client response scoreboard.
module tb_sram_arb;

  typedef struct packed {
    logic       we;
    logic [3:0] ad;
    logic [7:0] wd;
  } req_t;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  logic       clk;
  logic       rstn;
  logic       req0_valid;
  logic       req0_we;
  logic [3:0] req0_ad;
  logic [7:0] req0_wd;
  logic       req0_ready;
  logic       rsp0_valid;
  logic [7:0] rsp0_rd;
  logic       req1_valid;
  logic       req1_we;
  logic [3:0] req1_ad;
  logic [7:0] req1_wd;
  logic       req1_ready;
  logic       rsp1_valid;
  logic [7:0] rsp1_rd;
  logic       cs;
  logic       we;
  logic [3:0] ad;
  logic [7:0] wd;
  logic [7:0] rd;

  logic [7:0] sramMem [16];
  logic [7:0] refMem  [16];

  req_t q0[$];
  req_t q1[$];
  exp_t exp0[$];
  exp_t exp1[$];

  int         nCompared;
  int         nMismatched;
  int         cyc;
  int         rspCount0;
  int         rspCount1;
  int         wait0;
  int         wait1;
  bit         gate0;
  bit         modelLast;
  logic [3:0] lastAd;
  logic [7:0] lastWd;
  logic [7:0] hold0;
  logic [7:0] hold1;

  sram_arb #(.DEPTH(16), .WIDTH(8)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req0_valid (req0_valid),
    .req0_we    (req0_we),
    .req0_ad    (req0_ad),
    .req0_wd    (req0_wd),
    .req0_ready (req0_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_rd    (rsp0_rd),
    .req1_valid (req1_valid),
    .req1_we    (req1_we),
    .req1_ad    (req1_ad),
    .req1_wd    (req1_wd),
    .req1_ready (req1_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_rd    (rsp1_rd),
    .cs         (cs),
    .we         (we),
    .ad         (ad),
    .wd         (wd),
    .rd         (rd)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to time-stamp acceptances and responses.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port synchronous SRAM: rd valid the cycle after cs.
  always @(posedge clk) begin
    if (cs) begin
      if (we) sramMem[ad] <= wd;
      else    rd <= sramMem[ad];
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] expv);
    nCompared++;
    if (act !== expv) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  task automatic applyStimulus(input bit v0, input req_t r0, input bit v1, input req_t r1);
    req0_valid = v0;
    req0_we    = r0.we;
    req0_ad    = r0.ad;
    req0_wd    = r0.wd;
    req1_valid = v1;
    req1_we    = r1.we;
    req1_ad    = r1.ad;
    req1_wd    = r1.wd;
  endtask

  task automatic acceptReq(input int id, input req_t r, input int n);
    exp_t e;
    modelLast = (id == 1);
    lastAd    = r.ad;
    lastWd    = r.wd;
    if (r.we) begin
      refMem[r.ad] = r.wd;
    end else begin
      e.data = refMem[r.ad];
      e.due  = n + 3;
      if (id == 0) exp0.push_back(e);
      else         exp1.push_back(e);
    end
  endtask

  task automatic runCycle(input bit waitNeg);
    bit   v0, v1, eg0, eg1;
    req_t r0, r1;
    int   n;
    if (waitNeg) @(negedge clk);
    v0 = (q0.size() > 0) && gate0;
    v1 = (q1.size() > 0);
    r0 = v0 ? q0[0] : '0;
    r1 = v1 ? q1[0] : '0;
    applyStimulus(v0, r0, v1, r1);
    #1;
    eg0 = rstn && v0 && (!v1 || modelLast);
    eg1 = rstn && v1 && (!v0 || !modelLast);
    checkOutput("req0_ready", {15'd0, req0_ready}, {15'd0, eg0});
    checkOutput("req1_ready", {15'd0, req1_ready}, {15'd0, eg1});
    if (rstn) begin
      if (v0 && !req0_ready) wait0++; else wait0 = 0;
      if (v1 && !req1_ready) wait1++; else wait1 = 0;
      if (v0 && v1) begin
        checkOutput("wait0_le1", (wait0 > 1) ? 16'd1 : 16'd0, 16'd0);
        checkOutput("wait1_le1", (wait1 > 1) ? 16'd1 : 16'd0, 16'd0);
      end
    end
    n = cyc;
    @(posedge clk);
    if (eg0) acceptReq(0, q0.pop_front(), n);
    if (eg1) acceptReq(1, q1.pop_front(), n);
  endtask

  task automatic runUntilEmpty(input int maxCycles);
    int k = 0;
    while ((q0.size() > 0 || q1.size() > 0) && k < maxCycles) begin
      runCycle(1);
      k++;
    end
    checkOutput("drain_bound", (q0.size() + q1.size() != 0) ? 16'd1 : 16'd0, 16'd0);
    repeat (5) runCycle(1);
  endtask

  task automatic assertReset();
    rstn = 1'b0;
    exp0.delete();
    exp1.delete();
    modelLast = 1'b1;
    lastAd    = '0;
    lastWd    = '0;
    hold0     = '0;
    hold1     = '0;
    wait0     = 0;
    wait1     = 0;
  endtask

  task automatic releaseReset();
    @(negedge clk);
    #2 rstn = 1'b1;
    runCycle(0);
  endtask

  function automatic req_t mkReq(input logic w, input logic [3:0] a, input logic [7:0] d);
    req_t r;
    r.we = w;
    r.ad = a;
    r.wd = d;
    return r;
  endfunction

  // Response monitor: pops the scoreboard when a response falls due.
  always @(negedge clk) begin
    bit expV;
    if (rstn) begin
      expV = (exp0.size() > 0) && (exp0[0].due == cyc);
      checkOutput("rsp0_valid", {15'd0, rsp0_valid}, {15'd0, expV});
      if (rsp0_valid) rspCount0++;
      if (expV) begin
        if (rsp0_valid) checkOutput("rsp0_rd", {8'd0, rsp0_rd}, {8'd0, exp0[0].data});
        hold0 = exp0[0].data;
        void'(exp0.pop_front());
      end else if (!rsp0_valid) begin
        checkOutput("rsp0_hold", {8'd0, rsp0_rd}, {8'd0, hold0});
      end
      expV = (exp1.size() > 0) && (exp1[0].due == cyc);
      checkOutput("rsp1_valid", {15'd0, rsp1_valid}, {15'd0, expV});
      if (rsp1_valid) rspCount1++;
      if (expV) begin
        if (rsp1_valid) checkOutput("rsp1_rd", {8'd0, rsp1_rd}, {8'd0, exp1[0].data});
        hold1 = exp1[0].data;
        void'(exp1.pop_front());
      end else if (!rsp1_valid) begin
        checkOutput("rsp1_hold", {8'd0, rsp1_rd}, {8'd0, hold1});
      end
    end
  end

  // Hard stop in case anything stalls.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rspCount0   = 0;
    rspCount1   = 0;
    gate0       = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0);
    assertReset();

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_cs", {15'd0, cs}, 16'd0);
    checkOutput("rst_we", {15'd0, we}, 16'd0);
    checkOutput("rst_ad", {12'd0, ad}, 16'd0);
    checkOutput("rst_wd", {8'd0, wd}, 16'd0);
    checkOutput("rst_rsp0_valid", {15'd0, rsp0_valid}, 16'd0);
    checkOutput("rst_rsp1_valid", {15'd0, rsp1_valid}, 16'd0);
    checkOutput("rst_rsp0_rd", {8'd0, rsp0_rd}, 16'd0);
    checkOutput("rst_rsp1_rd", {8'd0, rsp1_rd}, 16'd0);

    // Client 0 alone: write i=i, then read back 0..15.
    $display("[TB] test 1: client 0 write/read sweep");
    for (int i = 0; i < 16; i++) q0.push_back(mkReq(1'b1, 4'(i), 8'(i)));
    for (int i = 0; i < 16; i++) q0.push_back(mkReq(1'b0, 4'(i), 8'd0));
    releaseReset();
    runUntilEmpty(100);
    checkOutput("t1_rsp0_count", 16'(rspCount0), 16'd16);
    checkOutput("t1_rsp1_count", 16'(rspCount1), 16'd0);

    // Both clients valid from reset; alternation must start with client 0.
    $display("[TB] test 2: contention from reset");
    @(negedge clk);
    #2 assertReset();
    rspCount0 = 0;
    rspCount1 = 0;
    for (int i = 0; i < 8; i++) q0.push_back(mkReq(1'b0, 4'(i), 8'd0));
    for (int i = 8; i < 16; i++) q1.push_back(mkReq(1'b0, 4'(i), 8'd0));
    runCycle(1);
    releaseReset();
    runUntilEmpty(100);
    checkOutput("t2_rsp0_count", 16'(rspCount0), 16'd8);
    checkOutput("t2_rsp1_count", 16'(rspCount1), 16'd8);
    checkOutput("t2_last_rsp0", {8'd0, rsp0_rd}, 16'h0007);
    checkOutput("t2_last_rsp1", {8'd0, rsp1_rd}, 16'h000F);

    // Write by client 1 followed next cycle by a read from client 0.
    $display("[TB] test 3: write then read same address");
    q1.push_back(mkReq(1'b1, 4'd3, 8'hA5));
    runCycle(1);
    q0.push_back(mkReq(1'b0, 4'd3, 8'd0));
    runUntilEmpty(20);
    checkOutput("t3_rsp0_rd", {8'd0, rsp0_rd}, 16'h00A5);

    // Client 1 held valid, client 0 toggling its valid each cycle.
    $display("[TB] test 4: toggling client 0 against steady client 1");
    for (int i = 0; i < 10; i++) begin
      q0.push_back(mkReq(1'b0, 4'(i), 8'd0));
      q1.push_back(mkReq(1'b0, 4'(15 - i), 8'd0));
    end
    for (int k = 0; k < 60 && (q0.size() > 0 || q1.size() > 0); k++) begin
      gate0 = ~gate0;
      runCycle(1);
    end
    gate0 = 1'b1;
    runUntilEmpty(20);

    // Reset while a read is in flight: the read must vanish.
    $display("[TB] test 5: reset during in-flight read");
    q0.push_back(mkReq(1'b0, 4'd5, 8'd0));
    runCycle(1);
    @(negedge clk);
    #1 checkOutput("t5_cs_issue", {15'd0, cs}, 16'd1);
    #1 assertReset();
    #1 checkOutput("t5_cs_async", {15'd0, cs}, 16'd0);
    rspCount0 = 0;
    rspCount1 = 0;
    q0.push_back(mkReq(1'b0, 4'd5, 8'd0));
    runCycle(1);
    releaseReset();
    runUntilEmpty(20);
    checkOutput("t5_rsp0_count", 16'(rspCount0), 16'd1);
    checkOutput("t5_rsp0_rd", {8'd0, rsp0_rd}, 16'h0005);

    // Idle: SRAM deselected, address and data held.
    $display("[TB] test 6: idle for 20 cycles");
    for (int k = 0; k < 20; k++) begin
      runCycle(1);
      #1;
      checkOutput("t6_cs", {15'd0, cs}, 16'd0);
      checkOutput("t6_we", {15'd0, we}, 16'd0);
      checkOutput("t6_ad", {12'd0, ad}, {12'd0, lastAd});
      checkOutput("t6_wd", {8'd0, wd}, {8'd0, lastWd});
    end

    checkOutput("exp0_left", 16'(exp0.size()), 16'd0);
    checkOutput("exp1_left", 16'(exp1.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
